mm_modexp_ctrl: RTL and testbench
=================================

Name: mm_modexp_ctrl

Overview:
- Left-to-right square-and-multiply controller for Montgomery modular exponentiation: result = base^exp in the Montgomery domain, computed as a chain of Montgomery products.
- Sits directly upstream of mm_r2mm_2n. It drives that multiplier's operands and request, and consumes its result/valid pulse.
- Operands arrive already in Montgomery form (base_m = a·R mod m, one_m = R mod m, R = 2^K). The result is returned in Montgomery form.

Parameters:
- K, 256, operand/modulus width; must match the attached multiplier (even, < 8191).
- E_W, 256, exponent width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_m  in  K  base in Montgomery form, < m
- one_m  in  K  R mod m
- exp  in  E_W  exponent
- m  in  K  odd modulus
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; result valid
- result  out  K  base^exp in Montgomery form; held until the next accepted start
- mm_x  out  K  multiplier operand x
- mm_y  out  K  multiplier operand y
- mm_m  out  K  multiplier modulus (latched m)
- mm_req  out  1  one-cycle request pulse to the multiplier
- mm_res  in  K  multiplier result
- mm_val  in  1  multiplier completion pulse

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous active-low. While reset is asserted:
  - busy, done and mm_req are 0; result, mm_x, mm_y and mm_m are 0; FSM is IDLE.
  - All internal registers (acc, base register, exponent register, bit index) are 0.
- start accepted in IDLE: latch base_m, one_m, exp and m; set the bit index to E_W-1; go to SCAN.
- start outside IDLE: ignored.
- SCAN (one exponent bit per cycle, from the MSB down):
  - Bit clear, index > 0: decrement the index.
  - Bit set at index i: acc ← base. If i = 0, go to DONE; else index ← i-1 and go to SQR_REQ.
  - Index 0 reached with the bit clear (exp = 0): acc ← one_m; go to DONE.
- SQR_REQ: drive mm_x = mm_y = acc and pulse mm_req for exactly one cycle; go to SQR_WAIT.
- SQR_WAIT:
  - Hold mm_x, mm_y and mm_m stable; the multiplier reads one x bit per cycle and requires stable operands until mm_val.
  - On mm_val: acc ← mm_res. If exp[index] = 1, go to MUL_REQ. Otherwise, if index = 0 go to DONE; else decrement the index and go to SQR_REQ.
- MUL_REQ: drive mm_x = acc, mm_y = base; pulse mm_req for one cycle; go to MUL_WAIT.
- MUL_WAIT: on mm_val, acc ← mm_res. If index = 0 go to DONE; else decrement the index and go to SQR_REQ.
- DONE: result ← acc; done = 1 for one cycle; busy = 0; return to IDLE.
- busy: high in every non-IDLE state except that it is 0 in the DONE cycle.
- mm_req timing:
  - mm_req is never high in two consecutive cycles.
  - Because the multiplier detects a 0→1 request edge, mm_req is low for at least one cycle between requests.
  - mm_req is never asserted while a multiply is outstanding.
- mm_val outside the WAIT states: ignored; no state change.
- Operation count: with the top set bit at position t, the run performs t squarings plus popcount(exp)-1 multiplies.
- exp = 1: no multiplier activity; result = base_m.
- exp = 0: no multiplier activity; result = one_m.
- Widths: acc and base registers are K bits. Multiplier outputs are already reduced below m, so no further reduction is done here.
- Reset mid-operation: abort immediately to IDLE; an outstanding mm_val after reset is ignored.

Test Plan:
- K=8, E_W=8, m=239, base_m=51 (a=3), one_m=17, exp=5, with mm_r2mm_2n attached → exactly 3 mm_req pulses (sqr, sqr, mul); done once; result=68 (3^5 mod 239 = 4, Montgomery form).
- Same setup, exp=0 → no mm_req; done exactly E_W+1 cycles after start; result=17.
- Same setup, exp=1 → no mm_req; result=51. Then exp=0x80 → 7 squarings, 0 multiplies; result = Montgomery form of 3^128 mod 239 (bench reference model).
- exp=0xFF, second start pulsed while busy and a spurious mm_val injected in SCAN → both ignored. Exactly 7 squarings + 7 multiplies; mm_x/mm_y stable across every WAIT; mm_req low between all pulses.
- rst_n dropped during SQR_WAIT of an exp=5 run → outputs zero asynchronously. After release, a fresh exp=5 start → result=68 with no corruption from the aborted multiply.
- Randomised K=8 operands (odd m, base_m < m), 200 runs → result matches the software model base_m^exp·R^(1-exp) mod m; done pulse count = start accept count.

Source files
------------

// File: rtl/mm_modexp_ctrl.sv
// Left-to-right square-and-multiply controller driving a Montgomery multiplier.
// Operands and result stay in the Montgomery domain; one exponent bit is consumed per step.
module mm_modexp_ctrl #(
  parameter int K   = 256,
  parameter int E_W = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [K-1:0]   base_m,
  input  logic [K-1:0]   one_m,
  input  logic [E_W-1:0] exp,
  input  logic [K-1:0]   m,
  output logic           busy,
  output logic           done,
  output logic [K-1:0]   result,
  output logic [K-1:0]   mm_x,
  output logic [K-1:0]   mm_y,
  output logic [K-1:0]   mm_m,
  output logic           mm_req,
  input  logic [K-1:0]   mm_res,
  input  logic           mm_val
);

  localparam int IW = (E_W > 1) ? $clog2(E_W) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SCAN     = 3'd1,
    SQR_REQ  = 3'd2,
    SQR_WAIT = 3'd3,
    MUL_REQ  = 3'd4,
    MUL_WAIT = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t         state_r, state_s;
  logic [K-1:0]   acc_r, acc_s;
  logic [K-1:0]   base_r, base_s;
  logic [K-1:0]   one_r, one_s;
  logic [K-1:0]   m_r, m_s;
  logic [K-1:0]   x_r, x_s;
  logic [K-1:0]   y_r, y_s;
  logic [K-1:0]   result_r, result_s;
  logic [E_W-1:0] exp_r, exp_s;
  logic [IW-1:0]  idx_r, idx_s;
  logic           busy_r, busy_s;
  logic           done_r, done_s;
  logic           req_r, req_s;
  logic           cur_bit_s;
  logic           idx_zero_s;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_s    = state_r;
    acc_s      = acc_r;
    base_s     = base_r;
    one_s      = one_r;
    m_s        = m_r;
    exp_s      = exp_r;
    idx_s      = idx_r;
    x_s        = x_r;
    y_s        = y_r;
    result_s   = result_r;
    cur_bit_s  = exp_r[idx_r];
    idx_zero_s = (idx_r == {IW{1'b0}});

    case (state_r)
      IDLE: begin
        if (start) begin
          base_s  = base_m;
          one_s   = one_m;
          exp_s   = exp;
          m_s     = m;
          idx_s   = IW'(E_W - 1);
          state_s = SCAN;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        // The first set bit seeds acc with the base; an all-zero exponent yields one_m
        if (cur_bit_s) begin
          acc_s = base_r;
          if (idx_zero_s) begin
            state_s = DONE;
          end else begin
            idx_s   = idx_r - IW'(1'b1);
            state_s = SQR_REQ;
          end
        end else if (idx_zero_s) begin
          acc_s   = one_r;
          state_s = DONE;
        end else begin
          idx_s = idx_r - IW'(1'b1);
        end
      end
      SQR_REQ: begin
        state_s = SQR_WAIT;
      end
      SQR_WAIT: begin
        if (mm_val) begin
          acc_s = mm_res;
          if (cur_bit_s) begin
            state_s = MUL_REQ;
          end else if (idx_zero_s) begin
            state_s = DONE;
          end else begin
            idx_s   = idx_r - IW'(1'b1);
            state_s = SQR_REQ;
          end
        end else begin
          state_s = SQR_WAIT;
        end
      end
      MUL_REQ: begin
        state_s = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (mm_val) begin
          acc_s = mm_res;
          if (idx_zero_s) begin
            state_s = DONE;
          end else begin
            idx_s   = idx_r - IW'(1'b1);
            state_s = SQR_REQ;
          end
        end else begin
          state_s = MUL_WAIT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Operands are loaded only on entry to a request state, so they hold through the wait
    if (state_s == SQR_REQ) begin
      x_s = acc_s;
      y_s = acc_s;
    end else if (state_s == MUL_REQ) begin
      x_s = acc_s;
      y_s = base_r;
    end else begin
      x_s = x_r;
      y_s = y_r;
    end

    req_s  = (state_s == SQR_REQ) || (state_s == MUL_REQ);
    busy_s = (state_s != IDLE) && (state_s != DONE);
    done_s = (state_s == DONE);

    if (done_s) begin
      result_s = acc_s;
    end else begin
      result_s = result_r;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      acc_r    <= {K{1'b0}};
      base_r   <= {K{1'b0}};
      one_r    <= {K{1'b0}};
      m_r      <= {K{1'b0}};
      x_r      <= {K{1'b0}};
      y_r      <= {K{1'b0}};
      result_r <= {K{1'b0}};
      exp_r    <= {E_W{1'b0}};
      idx_r    <= {IW{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      req_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      acc_r    <= acc_s;
      base_r   <= base_s;
      one_r    <= one_s;
      m_r      <= m_s;
      x_r      <= x_s;
      y_r      <= y_s;
      result_r <= result_s;
      exp_r    <= exp_s;
      idx_r    <= idx_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      req_r    <= req_s;
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign mm_x   = x_r;
  assign mm_y   = y_r;
  assign mm_m   = m_r;
  assign mm_req = req_r;

endmodule

// File: tb/tb_mm_modexp_ctrl.sv
// Bench for mm_modexp_ctrl: behavioural Montgomery multiplier with random latency,
// directed cases from the plan and randomised runs against a plain-arithmetic power model.
module tb_mm_modexp_ctrl;
  localparam int K   = 8;
  localparam int E_W = 8;
  localparam int LIMIT = 4000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [K-1:0]   base_m = '0;
  logic [K-1:0]   one_m = '0;
  logic [E_W-1:0] exp = '0;
  logic [K-1:0]   m = '0;
  logic           busy, done, mm_req;
  logic [K-1:0]   result, mm_x, mm_y, mm_m;
  logic [K-1:0]   mm_res = '0;
  logic           model_val = 1'b0;
  logic           inj_val = 1'b0;
  logic           mm_val;

  assign mm_val = model_val | inj_val;

  mm_modexp_ctrl #(.K(K), .E_W(E_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_m(base_m), .one_m(one_m),
    .exp(exp), .m(m), .busy(busy), .done(done), .result(result),
    .mm_x(mm_x), .mm_y(mm_y), .mm_m(mm_m), .mm_req(mm_req),
    .mm_res(mm_res), .mm_val(mm_val)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int req_cnt = 0;
  int done_cnt = 0;
  int accept_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // R^-1 mod md with R = 2^K, by search
  function automatic longint r_inv(input longint md);
    for (longint i = 1; i < md; i++) begin
      if (((longint'(1) << K) * i) % md == 1) return i;
    end
    return 0;
  endfunction

  function automatic longint mont_mul(input longint x, input longint y, input longint md);
    return (((x * y) % md) * r_inv(md)) % md;
  endfunction

  // Convert out of Montgomery form, raise to e by repeated multiplication, convert back
  function automatic longint ref_pow(input longint bm, input longint e, input longint md);
    longint a, p;
    a = (bm * r_inv(md)) % md;
    p = 1 % md;
    for (longint i = 0; i < e; i++) p = (p * a) % md;
    return (p * (longint'(1) << K)) % md;
  endfunction

  function automatic int ref_reqs(input int e);
    int top, pc;
    if (e == 0) return 0;
    top = 0;
    pc = 0;
    for (int i = 0; i < E_W; i++) begin
      if ((e >> i) & 1) begin
        top = i;
        pc++;
      end
    end
    return top + pc - 1;
  endfunction

  // Request/done monitor
  initial begin
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0;
      end else begin
        if (mm_req) begin
          req_cnt++;
          chk("req_gap", prev_req, 1'b0);
        end
        if (done) done_cnt++;
        prev_req = mm_req;
      end
    end
  end

  // Behavioural multiplier: captures operands on request, checks they hold, answers later
  initial begin
    logic [K-1:0] cx, cy, cm;
    int lat;
    bit aborted;
    forever begin
      @(negedge clk);
      model_val = 1'b0;
      if (rst_n && mm_req) begin
        cx = mm_x;
        cy = mm_y;
        cm = mm_m;
        lat = $urandom_range(1, 6);
        aborted = 1'b0;
        for (int c = 0; c < lat; c++) begin
          @(negedge clk);
          if (!rst_n) aborted = 1'b1;
          if (!aborted) begin
            chk("x_hold", mm_x, cx);
            chk("y_hold", mm_y, cy);
            chk("m_hold", mm_m, cm);
            chk("req_outstanding", mm_req, 1'b0);
          end
        end
        mm_res = K'(mont_mul(cx, cy, cm));
        model_val = 1'b1;
      end
    end
  end

  int last_cyc;

  task automatic run(input int bm, input int om, input int e, input int md,
                     input string tag, input bit disturb);
    int cyc, req0;
    @(negedge clk);
    base_m = K'(bm);
    one_m = K'(om);
    exp = E_W'(e);
    m = K'(md);
    start = 1'b1;
    req0 = req_cnt;
    @(negedge clk);
    start = 1'b0;
    accept_cnt++;
    cyc = 1;
    chk({tag, "_busy"}, busy, 1'b1);
    while (!done && cyc < LIMIT) begin
      if (disturb) begin
        if (cyc == 1) begin
          inj_val = 1'b1;
          start = 1'b1;
        end else if (cyc == 2) begin
          inj_val = 1'b0;
        end else if (cyc == 4) begin
          start = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    inj_val = 1'b0;
    last_cyc = cyc;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    chk({tag, "_result"}, result, ref_pow(bm, e, md));
    chk({tag, "_nreq"}, req_cnt - req0, ref_reqs(e));
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int md, bm, e, w;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_req", mm_req, 1'b0);
    chk("rst_result", result, 0);
    chk("rst_x", mm_x, 0);
    chk("rst_y", mm_y, 0);
    chk("rst_m", mm_m, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(51, 17, 5, 239, "exp5", 1'b0);
    chk("exp5_const", result, 68);
    run(51, 17, 0, 239, "exp0", 1'b0);
    chk("exp0_const", result, 17);
    chk("exp0_latency", last_cyc, E_W + 1);
    run(51, 17, 1, 239, "exp1", 1'b0);
    chk("exp1_const", result, 51);
    run(51, 17, 8'h80, 239, "exp80", 1'b0);
    run(51, 17, 8'hFF, 239, "expff", 1'b1);

    // Abort an exp=5 run while the first square is outstanding
    @(negedge clk);
    base_m = 8'd51; one_m = 8'd17; exp = 8'd5; m = 8'd239;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!mm_req && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("abort_saw_req", mm_req, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_req", mm_req, 1'b0);
    chk("abort_result", result, 0);
    chk("abort_x", mm_x, 0);
    chk("abort_y", mm_y, 0);
    chk("abort_m", mm_m, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_idle", busy, 1'b0);
    run(51, 17, 5, 239, "after_rst", 1'b0);
    chk("after_rst_const", result, 68);

    for (int r = 0; r < 200; r++) begin
      md = 2 * $urandom_range(1, 127) + 1;
      bm = $urandom_range(0, md - 1);
      e = $urandom_range(0, 255);
      run(bm, 256 % md, e, md, "rand", 1'b0);
    end

    repeat (10) @(negedge clk);
    chk("done_count", done_cnt, accept_cnt);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
